// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/bypass controller.
package pipe_hazard_pkg;

  localparam int unsigned SB_AW_MAX = 8;

  localparam int unsigned STG_EX = 0;
  localparam int unsigned STG_DM = 1;
  localparam int unsigned STG_WB = 2;
  localparam int unsigned NSTG   = 3;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [SB_AW_MAX-1:0] dst;
    logic                 load;
    logic                 hlt;
  } sb_slot_t;

  function automatic int unsigned calc_aw(input int unsigned nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/hz_sb_slot.sv
// One scoreboard slot: holds, clears to an empty entry, or loads the upstream entry.
module hz_sb_slot
  import pipe_hazard_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  input  logic     clear,
  input  sb_slot_t d,
  output sb_slot_t q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (!hold)
      q <= clear ? '0 : d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, bypass, flush and halt-drain controller for the 5-stage IM/ID/EX/DM/WB pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter  int unsigned NREG     = 16,
  parameter  int unsigned NSRC     = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = calc_aw(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [NSRC-1:0]    id_src_re,
  input  logic [NSRC*AW-1:0] id_src_addr,
  input  logic               id_we,
  input  logic [AW-1:0]      id_dst_addr,
  input  logic               id_is_load,
  input  logic               id_hlt,
  input  logic               flow_change_ID_EX,
  input  logic               dm_busy,
  output logic               stall_IM_ID,
  output logic               stall_ID_EX,
  output logic               stall_EX_DM,
  output logic               stall_DM_WB,
  output logic               bubble_ID_EX,
  output logic               flush_IM_ID,
  output logic               flush_ID_EX,
  output logic [NSRC-1:0]    byp_EX,
  output logic [NSRC-1:0]    byp_DM,
  output logic               hlt_DM_WB
);

  sb_slot_t             slot [NSTG];
  sb_slot_t             ex_d;
  logic [NSRC-1:0]      m_ex;
  logic [NSRC-1:0]      m_dm;
  logic [SB_AW_MAX-1:0] src_ext;
  logic                 zero_ok;
  logic                 hlt_flag;
  logic                 halt_active;
  logic                 flush;
  logic                 load_use;
  logic                 kill_id;

  always_comb begin
    m_ex    = '0;
    m_dm    = '0;
    src_ext = '0;
    zero_ok = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      src_ext         = '0;
      src_ext[AW-1:0] = id_src_addr[i*AW +: AW];
      zero_ok         = !((ZERO_REG != 0) && (src_ext == '0));
      m_ex[i] = id_valid && id_src_re[i] && zero_ok && slot[STG_EX].valid &&
                slot[STG_EX].we && (slot[STG_EX].dst == src_ext);
      m_dm[i] = id_valid && id_src_re[i] && zero_ok && slot[STG_DM].valid &&
                slot[STG_DM].we && (slot[STG_DM].dst == src_ext);
    end
  end

  always_comb begin
    halt_active = hlt_flag;
    for (int unsigned s = 0; s < NSTG; s++)
      halt_active = halt_active | (slot[s].valid & slot[s].hlt);
  end

  assign flush    = flow_change_ID_EX & ~dm_busy;
  assign load_use = (|m_ex) & slot[STG_EX].load & ~dm_busy & ~flush & ~halt_active;
  // Anything in ID while an HLT drains is younger than the HLT, so it never enters EX.
  assign kill_id  = flush | load_use | halt_active | ~id_valid;

  always_comb begin
    ex_d       = '0;
    ex_d.valid = id_valid;
    ex_d.we    = id_we;
    ex_d.dst   = SB_AW_MAX'(id_dst_addr);
    ex_d.load  = id_is_load;
    ex_d.hlt   = id_hlt;
  end

  hz_sb_slot u_slot_ex (
    .clk   (clk),
    .rst   (rst),
    .hold  (dm_busy),
    .clear (kill_id),
    .d     (ex_d),
    .q     (slot[STG_EX])
  );

  hz_sb_slot u_slot_dm (
    .clk   (clk),
    .rst   (rst),
    .hold  (dm_busy),
    .clear (1'b0),
    .d     (slot[STG_EX]),
    .q     (slot[STG_DM])
  );

  hz_sb_slot u_slot_wb (
    .clk   (clk),
    .rst   (rst),
    .hold  (dm_busy),
    .clear (1'b0),
    .d     (slot[STG_DM]),
    .q     (slot[STG_WB])
  );

  // The youngest producer wins: a DM match is ignored when EX also matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_EX <= '0;
      byp_DM <= '0;
    end else if (!dm_busy) begin
      if (kill_id) begin
        byp_EX <= '0;
        byp_DM <= '0;
      end else begin
        byp_EX <= m_ex & ~{NSRC{slot[STG_EX].load}};
        byp_DM <= m_dm & ~m_ex;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      hlt_flag <= 1'b0;
    else if (slot[STG_WB].valid && slot[STG_WB].hlt)
      hlt_flag <= 1'b1;
  end

  assign hlt_DM_WB    = hlt_flag;
  assign stall_DM_WB  = ~rst & dm_busy;
  assign stall_EX_DM  = ~rst & dm_busy;
  assign stall_ID_EX  = ~rst & (dm_busy | load_use);
  assign stall_IM_ID  = ~rst & (dm_busy | load_use | halt_active);
  assign bubble_ID_EX = ~rst & load_use;
  assign flush_ID_EX  = ~rst & flush;
  assign flush_IM_ID  = ~rst & ~dm_busy & (flow_change_ID_EX | halt_active);

endmodule
